sa_ws_array: RTL

Weight-stationary ROWS x COLS systolic array with an integrated control FSM, weight-preload counter, input skew and output deskew. It accepts whole weight rows, then streams ifmap vectors and returns one aligned psum vector per accepted ifmap vector. It sits between the ifmap/weight buffers and the accumulator stage of the MMU, and it generalises the square, uncontrolled PE mesh to rectangular arrays with a valid/ready front end.

---
 rtl/sa_ws_if.sv | 36 +++
 rtl/sa_ws_array.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sa_ws_if.sv
// sa_ws_if: weight-load, ifmap-stream and psum-result bundle of the systolic array.
// The psum_bias_i lane exists only when SA_BIAS_IN_EN is defined.
interface sa_ws_if #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32
);
    logic                       weight_valid_i;
    logic [DATA_WIDTH*COLS-1:0] weight_row_i;
    logic                       weight_ready_o;
    logic                       ifmap_valid_i;
    logic [DATA_WIDTH*ROWS-1:0] ifmap_vec_i;
    logic                       ifmap_ready_o;
    logic                       flush_i;
    logic                       psum_valid_o;
    logic [PSUM_WIDTH*COLS-1:0] psum_vec_o;
    logic                       busy_o;
`ifdef SA_BIAS_IN_EN
    logic [PSUM_WIDTH*COLS-1:0] psum_bias_i;
`endif
    modport master (
        output weight_valid_i, weight_row_i, ifmap_valid_i, ifmap_vec_i, flush_i,
`ifdef SA_BIAS_IN_EN
        output psum_bias_i,
`endif
        input  weight_ready_o, ifmap_ready_o, psum_valid_o, psum_vec_o, busy_o
    );
    modport slave (
        input  weight_valid_i, weight_row_i, ifmap_valid_i, ifmap_vec_i, flush_i,
`ifdef SA_BIAS_IN_EN
        input  psum_bias_i,
`endif
        output weight_ready_o, ifmap_ready_o, psum_valid_o, psum_vec_o, busy_o
    );
endinterface

// File: rtl/sa_ws_array.sv
// sa_ws_array: weight-stationary ROWS x COLS systolic array with load/compute/drain control.
// Define SA_BIAS_IN_EN to seed each column's row-0 psum from psum_bias_i.
module sa_ws_array #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32
) (
    input logic    clk,
    input logic    rst,
    sa_ws_if.slave bus
);
    localparam int CW = $clog2(ROWS + COLS + 1);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int AC = COLS > 1 ? COLS - 1 : 1;
    localparam int VL = ROWS + COLS - 1;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [RW-1:0]                widx;
    logic                         wr_q, ir_q, busy_q, pv_q;
    logic [PSUM_WIDTH*COLS-1:0]   pvec_q;
    logic                         xfer_w, xfer_x;
    logic [VL-1:0]                vp;
    logic signed [DATA_WIDTH-1:0] w       [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] lane_in [ROWS];
    logic signed [DATA_WIDTH-1:0] ain     [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] a       [ROWS][AC];
    logic signed [PSUM_WIDTH-1:0] seed    [COLS];
    logic signed [PSUM_WIDTH-1:0] pin     [ROWS][COLS];
    logic signed [PSUM_WIDTH-1:0] p       [ROWS][COLS];
    logic signed [PSUM_WIDTH-1:0] col_out [COLS];
    assign xfer_w             = bus.weight_valid_i & wr_q;
    assign xfer_x             = bus.ifmap_valid_i & ir_q;
    assign bus.weight_ready_o = wr_q;
    assign bus.ifmap_ready_o  = ir_q;
    assign bus.busy_o         = busy_q;
    assign bus.psum_valid_o   = pv_q;
    assign bus.psum_vec_o     = pvec_q;
    assign widx               = state == IDLE ? '0 : RW'(cnt);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_q   <= 1'b1;
            ir_q   <= 1'b0;
            busy_q <= 1'b0;
        end else
            case (state)
                IDLE: if (xfer_w) begin
                    state  <= ROWS == 1 ? COMPUTE : LOAD;
                    cnt    <= CW'(1);
                    wr_q   <= ROWS != 1;
                    ir_q   <= ROWS == 1;
                    busy_q <= 1'b1;
                end
                LOAD: if (xfer_w) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ROWS - 1)) begin
                        state <= COMPUTE;
                        wr_q  <= 1'b0;
                        ir_q  <= 1'b1;
                    end
                end
                COMPUTE: if (bus.flush_i) begin
                    state <= DRAIN;
                    cnt   <= CW'(ROWS + COLS);
                    ir_q  <= 1'b0;
                end
                DRAIN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state  <= IDLE;
                        wr_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
    always_ff @(posedge clk or posedge rst)
        if (rst) w <= '{default: '0};
        else if (xfer_w)
            for (int c = 0; c < COLS; c++)
                w[widx][c] <= bus.weight_row_i[DATA_WIDTH*c +: DATA_WIDTH];
    // lane r reaches column 0 after r cycles; idle cycles inject zeros
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic signed [DATA_WIDTH-1:0] x;
        assign x = xfer_x ? bus.ifmap_vec_i[DATA_WIDTH*r +: DATA_WIDTH] : '0;
        if (r == 0) begin : g_direct
            assign lane_in[r] = x;
        end else begin : g_delay
            logic signed [DATA_WIDTH-1:0] d [r];
            always_ff @(posedge clk or posedge rst)
                if (rst) d <= '{default: '0};
                else begin
                    d[0] <= x;
                    for (int i = 1; i < r; i++) d[i] <= d[i-1];
                end
            assign lane_in[r] = d[r-1];
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_seed
`ifdef SA_BIAS_IN_EN
        logic signed [PSUM_WIDTH-1:0] b;
        assign b = xfer_x ? bus.psum_bias_i[PSUM_WIDTH*c +: PSUM_WIDTH] : '0;
        if (c == 0) begin : g_direct
            assign seed[c] = b;
        end else begin : g_delay
            logic signed [PSUM_WIDTH-1:0] d [c];
            always_ff @(posedge clk or posedge rst)
                if (rst) d <= '{default: '0};
                else begin
                    d[0] <= b;
                    for (int i = 1; i < c; i++) d[i] <= d[i-1];
                end
            assign seed[c] = d[c-1];
        end
`else
        assign seed[c] = '0;
`endif
    end
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            ain[r][0] = lane_in[r];
            for (int c = 1; c < COLS; c++) ain[r][c] = a[r][c-1];
        end
        for (int c = 0; c < COLS; c++) pin[0][c] = seed[c];
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pin[r][c] = p[r-1][c];
    end
    // products are sign-extended to PSUM_WIDTH by context; sums wrap
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a <= '{default: '0};
            p <= '{default: '0};
        end else
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) p[r][c] <= pin[r][c] + ain[r][c] * w[r][c];
                for (int c = 0; c < COLS - 1; c++) a[r][c] <= ain[r][c];
            end
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        if (c == COLS - 1) begin : g_direct
            assign col_out[c] = p[ROWS-1][c];
        end else begin : g_delay
            logic signed [PSUM_WIDTH-1:0] d [COLS-1-c];
            always_ff @(posedge clk or posedge rst)
                if (rst) d <= '{default: '0};
                else begin
                    d[0] <= p[ROWS-1][c];
                    for (int i = 1; i < COLS - 1 - c; i++) d[i] <= d[i-1];
                end
            assign col_out[c] = d[COLS-2-c];
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vp     <= '0;
            pv_q   <= 1'b0;
            pvec_q <= '0;
        end else begin
            vp[0] <= xfer_x;
            for (int i = 1; i < VL; i++) vp[i] <= vp[i-1];
            pv_q <= vp[VL-1];
            if (vp[VL-1])
                for (int c = 0; c < COLS; c++) pvec_q[PSUM_WIDTH*c +: PSUM_WIDTH] <= col_out[c];
        end
endmodule
